// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - MIPS instruction encoder and imem program loader
// Packs symbolic requests into 32-bit words and writes them to consecutive imem words.
module instr_loader #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] base_addr,
  input  logic         finish,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_kind,
  input  logic [4:0]   in_rs,
  input  logic [4:0]   in_rt,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_shamt,
  input  logic [5:0]   in_funct,
  input  logic [15:0]  in_imm,
  input  logic [25:0]  in_target,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t       state;
  logic [n-1:0] addr;
  logic [31:0]  word;
  logic         fin_pend;
  logic [31:0]  enc_word;
  logic         legal;

  assign legal = (in_kind <= 3'd5);

  always_comb begin
    enc_word = 32'h0;
    case (in_kind)
      3'd0: enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1: enc_word = {6'h23, in_rs, in_rt, in_imm};
      3'd2: enc_word = {6'h2B, in_rs, in_rt, in_imm};
      3'd3: enc_word = {6'h04, in_rs, in_rt, in_imm};
      3'd4: enc_word = {6'h08, in_rs, in_rt, in_imm};
      3'd5: enc_word = {6'h02, in_target};
      default: enc_word = 32'h0;
    endcase
  end

  // Handshake-facing outputs decode the state register so reset drops them at once.
  assign in_ready  = (state == LOAD);
  assign mem_we    = (state == WRITE);
  assign busy      = (state == LOAD) || (state == WRITE);
  assign mem_addr  = addr;
  assign mem_wdata = word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      word       <= 32'h0;
      fin_pend   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= 16'h0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            addr       <= base_addr & {{(n-2){1'b1}}, 2'b00};
            word_count <= 16'h0;
            done       <= 1'b0;
            fin_pend   <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid && legal) begin
            word     <= enc_word;
            fin_pend <= finish;
            state    <= WRITE;
          end else begin
            // Illegal kinds are swallowed; finish still ends the session.
            if (in_valid) err <= 1'b1;
            if (finish) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (finish) fin_pend <= 1'b1;
          if (mem_ready) begin
            addr <= addr + n'(32'd4);
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            if (fin_pend || finish) begin
              state    <= DONE;
              done     <= 1'b1;
              fin_pend <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, finish, in_valid, mem_ready;
  logic [31:0] base_addr;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [31:0] m_addr;
  int          m_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_mode = 0;

  instr_loader #(.n(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference encoding built from opcode/field weights.
  function automatic logic [31:0] model_enc(input int k, input logic [31:0] rs, rt, rd, sh, fn, imm, tgt);
    logic [31:0] ops [6];
    logic [31:0] op;
    ops = '{32'd0, 32'd35, 32'd43, 32'd4, 32'd8, 32'd2};
    op = ops[k];
    if (k == 0) return rs * 32'h0020_0000 + rt * 32'h0001_0000 + rd * 32'h800 + sh * 32'd64 + fn;
    if (k == 5) return op * 32'h0400_0000 + tgt;
    return op * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000 + imm;
  endfunction

  // Write monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    wr_t e;
    #4;
    if (reset && mem_we && mem_ready) begin
      got_q.push_back('{mem_addr, mem_wdata});
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d) begin
          n_fail++;
          $display("FAIL write_model: got %h@%h, required %h@%h", mem_wdata, mem_addr, e.d, e.a);
        end
      end
    end
  end

  task automatic send(input int k, input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic fin);
    int t = 0;
    in_kind = 3'(k); in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_valid = 1'b1; finish = fin;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
      if (rand_mode) mem_ready = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    if (k <= 5) begin
      exp_q.push_back('{m_addr, model_enc(k, 32'(rs), 32'(rt), 32'(rd), 32'(sh), 32'(fn), 32'(imm), 32'(tgt))});
      m_addr = m_addr + 32'd4;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic send_rand(input int k, input logic fin);
    send(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
         16'($urandom), 26'($urandom), fin);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(in_ready || done) && t < 200) begin
      @(negedge clk);
      t++;
      if (rand_mode) mem_ready = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (!(in_ready || done)) begin
      n_fail++;
      $display("FAIL wait_idle_timeout: in_ready=%b done=%b, required one high", in_ready, done);
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1; base_addr = b;
    m_addr = b & 32'hFFFF_FFFC; m_cnt = 0;
    got_q.delete();
    @(negedge clk);
    start = 1'b0; base_addr = $urandom;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({mem_we, busy, done, err, in_ready} !== 5'b0 || word_count !== 16'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: we/busy/done/err/rdy=%b wc=%h addr=%h, required all 0",
               {mem_we, busy, done, err, in_ready}, word_count, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    do_start(32'h100);
    send(4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h7, 26'd0, 1'b0);
    wait_idle();
    mem_ready = 1'b0;
    send(0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
    n_checks++;
    if (mem_we !== 1'b1 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_pre_write: mem_we=%b wc=%0d, required 1 and 1", mem_we, word_count);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || word_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async: mem_we=%b busy=%b wc=%h, required 0 0 0", mem_we, busy, word_count);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: in_ready=%b busy=%b done=%b, required 0 0 0", in_ready, busy, done);
    end
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_in_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_basic();
    do_start(32'h0);
    send(4, 5'd0, 5'd8, 5'($urandom), 5'($urandom), 6'($urandom), 16'd5, 26'($urandom), 1'b0);
    send(0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'($urandom), 26'($urandom), 1'b0);
    wait_idle();
    n_checks++;
    if (word_count !== 16'd2) begin
      n_fail++;
      $display("FAIL basic_count: wc=%0d, required 2", word_count);
    end
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_writes: %0d writes, required 2", got_q.size());
    end else if (got_q[0].d !== 32'h20080005 || got_q[0].a !== 32'h0 ||
                 got_q[1].d !== 32'h01095020 || got_q[1].a !== 32'h4) begin
      n_fail++;
      $display("FAIL basic_words: %h@%h %h@%h, required 20080005@0 01095020@4",
               got_q[0].d, got_q[0].a, got_q[1].d, got_q[1].a);
    end
    do_finish();
  endtask

  task automatic test_stall();
    do_start(32'h0);
    send(1, 5'd8, 5'd9, 5'($urandom), 5'($urandom), 6'($urandom), 16'h4, 26'($urandom), 1'b0);
    send(3, 5'd8, 5'd9, 5'($urandom), 5'($urandom), 6'($urandom), 16'hFFFE, 26'($urandom), 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'h1109FFFE || mem_addr !== 32'h4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: we=%b data=%h addr=%h rdy=%b, required 1 1109fffe 4 0",
                 mem_we, mem_wdata, mem_addr, in_ready);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    send(5, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'h10, 1'b0);
    wait_idle();
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL stall_writes: %0d writes, required 3", got_q.size());
    end else if (got_q[0].d !== 32'h8D090004 || got_q[1].d !== 32'h1109FFFE || got_q[2].d !== 32'h08000010 ||
                 got_q[0].a !== 32'h0 || got_q[1].a !== 32'h4 || got_q[2].a !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_words: %h@%h %h@%h %h@%h, required 8d090004@0 1109fffe@4 08000010@8",
               got_q[0].d, got_q[0].a, got_q[1].d, got_q[1].a, got_q[2].d, got_q[2].a);
    end
    do_finish();
  endtask

  task automatic test_wrap();
    do_start(32'hFFFF_FFFE);
    send_rand(4, 1'b0);
    send_rand(4, 1'b0);
    wait_idle();
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_writes: %0d writes, required 2", got_q.size());
    end else if (got_q[0].a !== 32'hFFFF_FFFC || got_q[1].a !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: %h %h, required fffffffc 00000000", got_q[0].a, got_q[1].a);
    end
    do_finish();
  endtask

  task automatic test_illegal();
    logic [31:0] b;
    b = $urandom & 32'hFFFF_FFF0;
    do_start(b);
    send_rand(2, 1'b0);
    send_rand(7, 1'b0);
    n_checks++;
    if (err !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err: err=%b mem_we=%b, required 1 0", err, mem_we);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || mem_we !== 1'b0 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL illegal_after: err=%b mem_we=%b wc=%0d, required 0 0 1", err, mem_we, word_count);
    end
    send_rand(0, 1'b0);
    wait_idle();
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL illegal_writes: %0d writes, required 2", got_q.size());
    end else if (got_q[1].a !== b + 32'd4) begin
      n_fail++;
      $display("FAIL illegal_addr: %h, required %h", got_q[1].a, b + 32'd4);
    end
    do_finish();
  endtask

  task automatic test_finish_same_cycle();
    do_start(32'h40);
    send_rand(4, 1'b1);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'd1 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL finish_same: done=%b busy=%b wc=%0d writes=%0d, required 1 0 1 1",
               done, busy, word_count, got_q.size());
    end
    do_start(32'h80);
    n_checks++;
    if (done !== 1'b0 || word_count !== 16'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: done=%b wc=%0d busy=%b, required 0 0 1", done, word_count, busy);
    end
    do_finish();
  endtask

  task automatic test_random();
    int k;
    do_start($urandom);
    rand_mode = 1;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 7);
      send_rand(k, 1'b0);
      n_checks++;
      if (err !== (k > 5)) begin
        n_fail++;
        $display("FAIL random_err: kind=%0d err=%b, required %b", k, err, (k > 5));
      end
    end
    rand_mode = 0;
    mem_ready = 1'b1;
    wait_idle();
    n_checks++;
    if (word_count !== 16'(m_cnt)) begin
      n_fail++;
      $display("FAIL random_count: wc=%0d, required %0d", word_count, m_cnt);
    end
    do_finish();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    base_addr = '0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0; m_addr = '0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_illegal();
    test_finish_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Instruction encoder and program loader; the inverse of the op/funct control decode path.
- Accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS instruction word and writes it into instruction memory at consecutive word addresses.
- Used by benches and boot logic to place programs in imem before the CPU leaves reset.

Parameters:
- n, 32, address width of the imem write port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a load session at base_addr.
- base_addr  input  n  byte address of the first word; bits [1:0] are ignored (forced to 0).
- finish  input  1  pulse; ends the session.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- in_kind  input  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J; 6 and 7 are illegal.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
- in_funct  input  6  R-type funct; passed through unchanged.
- in_imm  input  16  immediate or branch offset.
- in_target  input  26  jump target.
- mem_we  output  1  imem write strobe.
- mem_addr  output  n  imem byte address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  imem accepts the write this cycle when mem_we & mem_ready.
- busy  output  1  session active (LOAD or WRITE).
- done  output  1  high from finish until the next start.
- err  output  1  one-cycle pulse when an illegal kind is accepted.
- word_count  output  16  number of words written this session.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal address and count cleared.
- Reset mid-session: the pending write is dropped immediately and mem_we falls asynchronously.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE --start--> LOAD:
  - addr <= {base_addr[n-1:2], 2'b00}
  - word_count <= 0
  - done <= 0
- In DONE, start behaves as in IDLE and clears done.
- LOAD:
  - in_ready=1.
  - On handshake with a legal kind: register the encoded word, go to WRITE.
  - On handshake with an illegal kind: consume and discard the request, pulse err next cycle, stay in LOAD.
  - finish (and no handshake): go to DONE, done=1.
  - If finish and a handshake occur in the same cycle: the request is accepted first (go to WRITE); finish is latched and applied after that write completes.
- WRITE:
  - in_ready=0; mem_we=1; mem_addr and mem_wdata held stable.
  - On mem_ready: addr += 4 (wraps modulo 2^n), word_count += 1 (saturates at 0xFFFF), then go to LOAD, or to DONE if finish is latched.
- Latency: a request accepted on cycle k drives mem_we from cycle k+1. Peak throughput is one word every 2 cycles.
- start outside IDLE/DONE is ignored. finish in IDLE is ignored.
- Encoding (fields listed MSB to LSB):
  - R: 000000, rs, rt, rd, shamt, funct.
  - LW: 100011, rs, rt, imm.
  - SW: 101011, rs, rt, imm.
  - BEQ: 000100, rs, rt, imm.
  - ADDI: 001000, rs, rt, imm.
  - J: 000010, target.
- Fields unused by a kind are ignored.
- busy = state is LOAD or WRITE.

Test Plan:
- Reset low mid-WRITE (mem_ready held 0): mem_we, busy and word_count go to 0 immediately; after release the FSM is in IDLE with in_ready=0.
- start base_addr=0x00000000; ADDI rs=0 rt=8 imm=5, then R rs=8 rt=9 rd=10 funct=0x20 -> writes 0x20080005 @0x0 and 0x01095020 @0x4; word_count=2.
- LW rs=8 rt=9 imm=4; BEQ rs=8 rt=9 imm=0xFFFE; J target=0x10; mem_ready held low 3 cycles on the BEQ write -> 0x8D090004, 0x1109FFFE (held stable until accepted), 0x08000010; addresses 0x0/0x4/0x8.
- base_addr=0xFFFFFFFE, two ADDI requests -> writes @0xFFFFFFFC then @0x00000000 (wrap).
- in_kind=7 accepted -> no mem_we; err pulses for exactly 1 cycle; word_count unchanged; the next legal request is written at the unchanged address.
- finish asserted in the same cycle as a handshake -> that word is still written, then done=1 and busy=0; a new start clears done and word_count.
